// File: rtl/mesi_l1_req_fsm.sv
// rtl/mesi_l1_req_fsm.sv - MESI L1 request FSM with line-state array and incoming-snoop handling
// Optional feature macro: SNP_TIMEOUT_EN (adds SNP_WAIT timeout reported through done_err_o).
module mesi_l1_req_fsm #(
   parameter int IDX_W   = 4,
   parameter int SNP_TMO = 64
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   // CPU request
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic             req_wr_i,
   input  logic [IDX_W-1:0] req_idx_i,
   // completion
   output logic             done_o,
   output logic [2:0]       done_st_o,
   output logic             done_err_o,
   // outgoing bus snoop request / response
   output logic             snp_req_valid_o,
   input  logic             snp_req_ready_i,
   output logic [2:0]       snp_req_o,
   input  logic             snp_rsp_valid_i,
   input  logic [1:0]       snp_rsp_i,
   // incoming snoop from another cache
   input  logic             ext_valid_i,
   input  logic [2:0]       ext_code_i,
   input  logic [IDX_W-1:0] ext_idx_i,
   output logic             ext_hitm_o
);

   // MESI line states
   localparam logic [2:0] INVALID   = 3'd0;
   localparam logic [2:0] SHARED    = 3'd1;
   localparam logic [2:0] EXCLUSIVE = 3'd2;
   localparam logic [2:0] MODIFIED  = 3'd3;

   // snoop request codes
   localparam logic [2:0] SNP_NO_REQ = 3'd0;
   localparam logic [2:0] SNP_RD     = 3'd1;
   localparam logic [2:0] SNP_RWITM  = 3'd2;
   localparam logic [2:0] SNP_INV    = 3'd3;

   // snoop response codes; the other two encodings are ignored
   localparam logic [1:0] SNP_FOUND = 2'd1;
   localparam logic [1:0] SNP_FETCH = 2'd2;

   localparam int NLINES = 1 << IDX_W;

   // a zero timeout would make SNP_WAIT expire before it is entered
   if (SNP_TMO < 1) begin : g_bad_tmo
      $error("SNP_TMO must be at least 1");
   end

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      LOOKUP   = 3'd1,
      SNP_REQ  = 3'd2,
      SNP_WAIT = 3'd3,
      UPDATE   = 3'd4
   } fsm_e;

   fsm_e             state_q, state_d;
   logic             wr_q, wr_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [2:0]       code_q, code_d;
   logic [2:0]       new_st_q, new_st_d;
   logic             we_q, we_d;
   logic             err_q, err_d;

   logic [2:0]       lines_q [NLINES];
   logic             ext_hitm_q, ext_hitm_d;

   logic [2:0]       cur_st;
   logic             lookup_hit;
   logic [2:0]       miss_code;
   logic             rsp_ok;
   logic [2:0]       fill_st;
   logic [2:0]       ext_cur_st;
   logic [2:0]       ext_next_st;
   logic             ext_code_ok;
   logic             tmo_hit;

   // registered array value of the latched line; no bypass of same-cycle snoops
   assign cur_st = lines_q[idx_q];

   // hit: any valid state for reads, owned (E/M) state for writes
   assign lookup_hit = wr_q ? ((cur_st == EXCLUSIVE) || (cur_st == MODIFIED))
                            : (cur_st != INVALID);

   // write to a SHARED line only needs to invalidate other copies
   assign miss_code = !wr_q              ? SNP_RD  :
                      (cur_st == SHARED) ? SNP_INV : SNP_RWITM;

   assign rsp_ok = snp_rsp_valid_i &&
                   ((snp_rsp_i == SNP_FOUND) || (snp_rsp_i == SNP_FETCH));

   // reads fill SHARED when another cache holds the line; writes always end MODIFIED
   assign fill_st = (code_q != SNP_RD)       ? MODIFIED :
                    (snp_rsp_i == SNP_FOUND) ? SHARED   : EXCLUSIVE;

`ifdef SNP_TIMEOUT_EN
   localparam int TMO_W = (SNP_TMO > 1) ? $clog2(SNP_TMO) : 1;

   logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

   assign tmo_hit = (state_q == SNP_WAIT) && (tmo_cnt_q == TMO_W'(SNP_TMO - 1));

   // timeout counter: zeroed while requesting, counts each cycle spent waiting
   always_comb begin
      tmo_cnt_d = tmo_cnt_q;
      if (state_q == SNP_REQ) begin
         tmo_cnt_d = '0;
      end else if ((state_q == SNP_WAIT) && !tmo_hit) begin
         tmo_cnt_d = tmo_cnt_q + 1'b1;
      end
   end

   // timeout counter register
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         tmo_cnt_q <= '0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
      end
   end
`else
   assign tmo_hit = 1'b0;
`endif

   // FSM state and transaction context registers
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q  <= IDLE;
         wr_q     <= 1'b0;
         idx_q    <= '0;
         code_q   <= SNP_NO_REQ;
         new_st_q <= INVALID;
         we_q     <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_q     <= wr_d;
         idx_q    <= idx_d;
         code_q   <= code_d;
         new_st_q <= new_st_d;
         we_q     <= we_d;
         err_q    <= err_d;
      end
   end

   // next-state and transaction context update
   always_comb begin
      state_d  = state_q;
      wr_d     = wr_q;
      idx_d    = idx_q;
      code_d   = code_q;
      new_st_d = new_st_q;
      we_d     = we_q;
      err_d    = err_q;
      unique case (state_q)
         IDLE: begin
            if (req_valid_i) begin
               wr_d    = req_wr_i;
               idx_d   = req_idx_i;
               we_d    = 1'b0;
               err_d   = 1'b0;
               state_d = LOOKUP;
            end
         end
         LOOKUP: begin
            if (lookup_hit) begin
               new_st_d = wr_q ? MODIFIED : cur_st;
               we_d     = 1'b1;
               state_d  = UPDATE;
            end else begin
               code_d  = miss_code;
               state_d = SNP_REQ;
            end
         end
         SNP_REQ: begin
            if (snp_req_ready_i) begin
               state_d = SNP_WAIT;
            end
         end
         SNP_WAIT: begin
            if (rsp_ok) begin
               new_st_d = fill_st;
               we_d     = 1'b1;
               state_d  = UPDATE;
            end else if (tmo_hit) begin
               // give up: leave the line untouched and report the error
               we_d    = 1'b0;
               err_d   = 1'b1;
               state_d = UPDATE;
            end
         end
         UPDATE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // FSM-driven outputs
   always_comb begin
      req_ready_o     = (state_q == IDLE);
      snp_req_valid_o = (state_q == SNP_REQ);
      snp_req_o       = (state_q == SNP_REQ) ? code_q : SNP_NO_REQ;
      done_o          = (state_q == UPDATE);
      done_st_o       = INVALID;
      if (state_q == UPDATE) begin
         done_st_o = err_q ? cur_st : new_st_q;
      end
`ifdef SNP_TIMEOUT_EN
      done_err_o = (state_q == UPDATE) && err_q;
`else
      done_err_o = 1'b0;
`endif
   end

   // incoming snoop: downgrade or invalidate the addressed line
   assign ext_cur_st  = lines_q[ext_idx_i];
   assign ext_code_ok = (ext_code_i == SNP_RD) || (ext_code_i == SNP_RWITM) ||
                        (ext_code_i == SNP_INV);

   // next line state under an incoming snoop
   always_comb begin
      ext_next_st = ext_cur_st;
      case (ext_code_i)
         SNP_RD: begin
            if ((ext_cur_st == MODIFIED) || (ext_cur_st == EXCLUSIVE)) begin
               ext_next_st = SHARED;
            end
         end
         SNP_RWITM, SNP_INV: begin
            ext_next_st = INVALID;
         end
         default: begin
            ext_next_st = ext_cur_st;
         end
      endcase
   end

   assign ext_hitm_d = ext_valid_i && ext_code_ok && (ext_cur_st == MODIFIED);

   // line-state array; the UPDATE write is last so it wins on an index collision
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < NLINES; i++) begin
            lines_q[i] <= INVALID;
         end
      end else begin
         if (ext_valid_i) begin
            lines_q[ext_idx_i] <= ext_next_st;
         end
         if ((state_q == UPDATE) && we_q) begin
            lines_q[idx_q] <= new_st_q;
         end
      end
   end

   // writeback-needed pulse, one cycle after the snoop that hit a MODIFIED line
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         ext_hitm_q <= 1'b0;
      end else begin
         ext_hitm_q <= ext_hitm_d;
      end
   end

   assign ext_hitm_o = ext_hitm_q;

endmodule
